// File: rtl/ifetch_queue.sv
// ifetch_queue -- instruction-fetch front end.
//
// Owns the fetch PC and issues one outstanding word read at a time to
// instruction memory. Each returned {pc, instr} pair goes into a DEPTH-entry
// FIFO, and decode takes entries from that FIFO with a valid/ready handshake.
// A redirect (taken branch or jump) flushes the FIFO and restarts fetch at
// the new PC. If a request is still in flight when the redirect arrives, that
// request is completed and its data is thrown away.
//
// Parameters:
//   DEPTH     FIFO entries; a power of 2 from 2 to 16
//   RESET_PC  fetch PC after reset
//
// Ports:
//   Clk          in   1   clock; all state changes on its rising edge
//   PcReSet      in   1   asynchronous, active-high reset
//   redirect     in   1   branch/jump taken; one-cycle pulse
//   redirect_pc  in   32  new fetch PC; bits [1:0] are forced to 00
//   imem_req     out  1   read request; registered
//   imem_addr    out  32  word address of the request; registered
//   imem_ack     in   1   read done; sampled only while imem_req=1
//   imem_rdata   in   32  read data; valid in the imem_ack cycle
//   inst_valid   out  1   FIFO non-empty
//   inst_ready   in   1   decode accepts the head entry
//   inst_word    out  32  head instruction; 0 when empty
//   inst_pc      out  32  head PC; 0 when empty
//   flush_cnt    out  16  saturating count of work discarded by redirects
//                         (present only when IFQ_FLUSH_CNT_EN is defined)
//
// Optional feature macro: IFQ_FLUSH_CNT_EN

module ifetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        PcReSet,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc
`ifdef IFQ_FLUSH_CNT_EN
  ,
  output logic [15:0] flush_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DROP
  } state_t;

  state_t      r_state, w_state_next;
  logic        r_imem_req, w_imem_req_next;
  logic [31:0] r_imem_addr, w_imem_addr_next;
  logic [31:0] r_fetch_pc, w_fetch_pc_next;

  logic [AW:0]   r_count;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [31:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_word [DEPTH];

  logic        w_ack, w_pop, w_push, w_space;
  logic [31:0] w_redirect_pc;

  // In REQ and DROP, imem_req is always high, so this gating only matters in
  // IDLE. There it makes the FSM ignore a late ack.
  assign w_ack         = r_imem_req & imem_ack;
  assign w_pop         = inst_valid & inst_ready;
  // Space is reserved when a request is issued. Only one request can be
  // outstanding, and IDLE has none, so checking the occupancy is enough.
  assign w_space       = (r_count < C_DEPTH);
  assign w_redirect_pc = redirect_pc & ~32'd3;

  // ---------------- fetch FSM ----------------
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_state     <= S_IDLE;
      r_imem_req  <= 1'b0;
      r_imem_addr <= RESET_PC;
      r_fetch_pc  <= RESET_PC;
    end else begin
      r_state     <= w_state_next;
      r_imem_req  <= w_imem_req_next;
      r_imem_addr <= w_imem_addr_next;
      r_fetch_pc  <= w_fetch_pc_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_imem_req_next  = r_imem_req;
    w_imem_addr_next = r_imem_addr;
    w_fetch_pc_next  = r_fetch_pc;
    w_push           = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!redirect && w_space) begin
          w_imem_req_next  = 1'b1;
          w_imem_addr_next = r_fetch_pc;
          w_state_next     = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          // The request cannot be withdrawn. If the ack has not arrived yet,
          // wait in DROP and discard the data when it does.
          if (w_ack) begin
            w_imem_req_next = 1'b0;
            w_state_next    = S_IDLE;
          end else begin
            w_state_next    = S_DROP;
          end
        end else if (w_ack) begin
          w_push          = 1'b1;
          w_fetch_pc_next = r_fetch_pc + 32'd4;
          w_imem_req_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      S_DROP: begin
        if (w_ack) begin
          w_imem_req_next = 1'b0;
          w_state_next    = S_IDLE;
        end
      end
      default: begin
        w_imem_req_next = 1'b0;
        w_state_next    = S_IDLE;
      end
    endcase

    // A redirect overrides any PC update made above.
    if (redirect) begin
      w_fetch_pc_next = w_redirect_pc;
    end
  end

  assign imem_req  = r_imem_req;
  assign imem_addr = r_imem_addr;

  // ---------------- FIFO ----------------
  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (redirect) begin
      // Flush. Any push or pop in the same cycle is discarded with it.
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // The storage has no reset. The occupancy count alone decides which
  // entries are valid.
  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_fifo_pc[r_wr_ptr]   <= r_imem_addr;
      r_fifo_word[r_wr_ptr] <= imem_rdata;
    end
  end

  assign inst_valid = (r_count != '0);
  assign inst_pc    = inst_valid ? r_fifo_pc[r_rd_ptr]   : 32'd0;
  assign inst_word  = inst_valid ? r_fifo_word[r_rd_ptr] : 32'd0;

`ifdef IFQ_FLUSH_CNT_EN
  // ---------------- flush counter ----------------
  // Each redirect adds the number of entries flushed, plus one if a
  // request is in REQ. A REQ request is discarded whether or not its ack
  // arrives in the same cycle. A request already in DROP was counted by the
  // redirect that orphaned it.
  logic [15:0] r_flush_cnt;
  logic [16:0] w_flush_sum;

  assign w_flush_sum = {1'b0, r_flush_cnt} + 17'(r_count) + 17'(r_state == S_REQ);

  always_ff @(posedge Clk or posedge PcReSet) begin
    if (PcReSet) begin
      r_flush_cnt <= 16'd0;
    end else if (redirect) begin
      r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
    end
  end

  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
module tb_ifetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        Clk;
  logic        PcReSet;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
`ifdef IFQ_FLUSH_CNT_EN
  logic [15:0] flush_cnt;
`endif

  ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk         (Clk),
    .PcReSet     (PcReSet),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_word   (inst_word),
    .inst_pc     (inst_pc)
`ifdef IFQ_FLUSH_CNT_EN
    ,
    .flush_cnt   (flush_cnt)
`endif
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  logic mem_en    = 1'b0;
  int   ack_delay = 0;
  int   ack_cnt   = 0;

  initial begin
    forever begin
      @(posedge Clk);
      #1;
      if (mem_en) begin
        if (PcReSet || !imem_req) begin
          imem_ack = 1'b0;
          ack_cnt  = 0;
        end else if (ack_cnt >= ack_delay) begin
          imem_ack   = 1'b1;
          imem_rdata = $urandom;
          ack_cnt    = 0;
        end else begin
          imem_ack = 1'b0;
          ack_cnt++;
        end
      end
    end
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        sb_q[$];
  logic [31:0] m_pc       = RESET_PC;
  logic [31:0] m_req_addr = '0;
  bit          m_busy      = 0;
  bit          m_drop      = 0;
  bit          m_exp_valid = 0;
  bit          m_exp_issue = 0;
  int          n_push = 0;
  int          n_pop  = 0;

  always @(negedge Clk) begin
    if (PcReSet) begin
      sb_q.delete();
      m_pc        = RESET_PC;
      m_busy      = 0;
      m_drop      = 0;
      m_exp_valid = 0;
    end else begin
      if (m_exp_valid) chk("issue", 32'(imem_req), 32'(m_exp_issue));
      if (m_busy) begin
        chk("req_held", 32'(imem_req), 32'd1);
        chk("addr_held", imem_addr, m_req_addr);
      end else if (imem_req) begin
        chk("req_addr", imem_addr, m_pc);
        m_busy     = 1;
        m_req_addr = m_pc;
      end
      m_exp_valid = !imem_req;
      m_exp_issue = !redirect && (sb_q.size() < DEPTH);

      chk("valid", 32'(inst_valid), 32'(sb_q.size() != 0));
      if (sb_q.size() != 0) begin
        chk("head_pc", inst_pc, sb_q[0].pc);
        chk("head_word", inst_word, sb_q[0].word);
      end else begin
        chk("empty_pc", inst_pc, 32'd0);
        chk("empty_word", inst_word, 32'd0);
      end

      if (!redirect && inst_ready && sb_q.size() != 0) begin
        void'(sb_q.pop_front());
        n_pop++;
      end
      if (m_busy && imem_ack) begin
        if (!redirect && !m_drop) begin
          sb_q.push_back({m_req_addr, imem_rdata});
          m_pc = m_pc + 32'd4;
          n_push++;
        end
        m_busy = 0;
        m_drop = 0;
      end else if (m_busy && redirect) begin
        m_drop = 1;
      end
      if (redirect) begin
        sb_q.delete();
        m_pc = redirect_pc & ~32'd3;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic wait_req(input logic lvl, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      step(1);
      if (imem_req == lvl) break;
    end
    chk(tag, 32'(imem_req), 32'(lvl));
  endtask

  task automatic wait_fill(input int n, input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      if (sb_q.size() == n) break;
      step(1);
    end
    chk(tag, 32'(sb_q.size()), 32'(n));
  endtask

  // Ends at posedge+1 with PcReSet just released.
  task automatic do_reset();
    PcReSet    = 1'b1;
    mem_en     = 1'b0;
    imem_ack   = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    ack_delay  = 0;
    step(2);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_word", inst_word, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
`ifdef IFQ_FLUSH_CNT_EN
    chk("rst_flush", 32'(flush_cnt), 32'd0);
`endif
    PcReSet = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    PcReSet     = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    inst_ready  = 1'b0;

    // 1: streaming with immediate acks and a ready consumer
    do_reset();
    inst_ready = 1'b1;
    mem_en     = 1'b1;
    n_pop      = 0;
    step(1);
    chk("t1_first_req", 32'(imem_req), 32'd1);
    chk("t1_first_addr", imem_addr, RESET_PC);
    step(10);
    chk("t1_pops", 32'(n_pop >= 3), 32'd1);
    $display("t1 streaming: %0d words popped", n_pop);

    // 2: fill the FIFO with decode stalled, then drain
    do_reset();
    mem_en = 1'b1;
    n_push = 0;
    step(20);
    chk("t2_pushes", 32'(n_push), 32'd4);
    chk("t2_req_idle", 32'(imem_req), 32'd0);
    chk("t2_full_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    wait_req(1'b1, 10, "t2_wait_req");
    chk("t2_next_addr", imem_addr, 32'h0000_3010);
    step(10);
    $display("t2 fill/drain: %0d pushes while stalled", 4);

    // 3: redirect while in REQ; late ack must be dropped
    do_reset();
    inst_ready = 1'b1;
    ack_delay  = 2;
    mem_en     = 1'b1;
    wait_req(1'b1, 5, "t3_wait_req");
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3043;
    step(1);
    redirect = 1'b0;
    wait_req(1'b0, 10, "t3_wait_drop_done");
    chk("t3_valid_after_drop", 32'(inst_valid), 32'd0);
    wait_req(1'b1, 5, "t3_wait_req2");
    chk("t3_next_addr", imem_addr, 32'h0000_3040);
    step(8);
    $display("t3 redirect in REQ: resumed at %h", 32'h0000_3040);

    // 4: redirect coinciding with ack and pop, two entries queued
    do_reset();
    mem_en = 1'b1;
    wait_fill(2, 20, "t4_fill");
    mem_en   = 1'b0;
    imem_ack = 1'b0;
    wait_req(1'b1, 5, "t4_wait_req");
    imem_ack    = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    inst_ready  = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_4000;
    step(1);
    imem_ack = 1'b0;
    redirect = 1'b0;
    chk("t4_valid", 32'(inst_valid), 32'd0);
`ifdef IFQ_FLUSH_CNT_EN
    chk("t4_flush_cnt", 32'(flush_cnt), 32'd3);
`endif
    mem_en = 1'b1;
    wait_req(1'b1, 5, "t4_wait_req2");
    chk("t4_next_addr", imem_addr, 32'h0000_4000);
    step(6);
    $display("t4 redirect+ack+pop: FIFO flushed, resumed at %h", 32'h0000_4000);

    // 5: reset mid-REQ with three entries queued; late ack ignored
    do_reset();
    mem_en = 1'b1;
    wait_fill(3, 20, "t5_fill");
    mem_en   = 1'b0;
    imem_ack = 1'b0;
    wait_req(1'b1, 5, "t5_wait_req");
    PcReSet = 1'b1;
    #1;
    chk("t5_req_rst", 32'(imem_req), 32'd0);
    chk("t5_valid_rst", 32'(inst_valid), 32'd0);
    chk("t5_addr_rst", imem_addr, RESET_PC);
    step(1);
    PcReSet    = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_0BAD;
    step(1);
    imem_ack = 1'b0;
    chk("t5_req_after", 32'(imem_req), 32'd1);
    chk("t5_addr_after", imem_addr, RESET_PC);
    chk("t5_valid_after", 32'(inst_valid), 32'd0);
    inst_ready = 1'b1;
    mem_en     = 1'b1;
    step(8);
    $display("t5 reset mid-REQ: restarted at %h", RESET_PC);

    // 6: PC wrap from 0xFFFF_FFFC
    do_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    inst_ready  = 1'b1;
    mem_en      = 1'b1;
    step(1);
    redirect = 1'b0;
    chk("t6_no_issue", 32'(imem_req), 32'd0);
    wait_req(1'b1, 5, "t6_wait_req");
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    wait_req(1'b0, 5, "t6_wait_ack");
    wait_req(1'b1, 5, "t6_wait_req2");
    chk("t6_wrap_addr", imem_addr, 32'h0000_0000);
    step(6);
    $display("t6 wrap: next address %h", 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
